// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared width codes, FSM encoding and access checks for the LSU
package lsu_pkg;

  // RV32I load/store width codes carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size carried in funct3[1:0]; funct3[2] selects zero extension
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    LDW  = 3'd3,
    RESP = 3'd4
  } lsu_state_t;

  // An access is rejected when misaligned for its width or when the width
  // code is not a legal load/store encoding (unsigned codes are load-only).
  function automatic logic access_err(input logic [2:0] funct3,
                                      input logic       write,
                                      input logic [1:0] addr_lo);
    logic err;
    case (funct3)
      F3_B:    err = 1'b0;
      F3_H:    err = addr_lo[0];
      F3_W:    err = (addr_lo != 2'b00);
      F3_BU:   err = write;
      F3_HU:   err = write | addr_lo[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and store byte-lane merge
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic        sign_ext;

  // Select the addressed byte and half out of the memory word
  always_comb begin
    lane_byte = word[7:0];
    case (addr_lo)
      2'd0: lane_byte = word[7:0];
      2'd1: lane_byte = word[15:8];
      2'd2: lane_byte = word[23:16];
      2'd3: lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
    lane_half = addr_lo[1] ? word[31:16] : word[15:0];
    sign_ext  = ~funct3[2];
  end

  // Extend the selected lane to 32 bits; word accesses pass straight through
  always_comb begin
    load_data = word;
    case (funct3[1:0])
      SZ_B:    load_data = {{24{sign_ext & lane_byte[7]}}, lane_byte};
      SZ_H:    load_data = {{16{sign_ext & lane_half[15]}}, lane_half};
      default: load_data = word;
    endcase
  end

  // Replace only the addressed byte or half of the old word with store data
  always_comb begin
    store_word = word;
    case (funct3[1:0])
      SZ_B: begin
        case (addr_lo)
          2'd0: store_word[7:0]   = wdata[7:0];
          2'd1: store_word[15:8]  = wdata[7:0];
          2'd2: store_word[23:16] = wdata[7:0];
          2'd3: store_word[31:24] = wdata[7:0];
          default: store_word = word;
        endcase
      end
      SZ_H: begin
        if (addr_lo[1]) store_word[31:16] = wdata[15:0];
        else            store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit controller with loader port and sub-word RMW
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        funct3_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [ADDR_W-1:0] ld_addr_q;
  logic [31:0]       ld_wdata_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic [31:0]       load_data;
  logic [31:0]       store_word;
  logic              cpu_take;
  logic              ld_take;
  logic              req_bad;

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // The loader wins whenever it asks; the CPU only sees ready when it is quiet
  always_comb begin
    ld_ready  = (state == IDLE);
    req_ready = (state == IDLE) && !ld_valid;
    ld_take   = ld_ready && ld_valid;
    cpu_take  = req_ready && req_valid;
    req_bad   = access_err(req_funct3, req_write, req_addr[1:0]);
  end

  // Memory port decoded from the registered state; writes are cut by reset
  always_comb begin
    mem_addr       = '0;
    mem_write_data = 32'h0;
    case (state)
      RD: mem_addr = addr_q >> 2;
      WR: begin
        mem_addr       = addr_q >> 2;
        mem_write_data = (funct3_q == F3_W) ? wdata_q : merge_q;
      end
      LDW: begin
        mem_addr       = ld_addr_q;
        mem_write_data = ld_wdata_q;
      end
      default: begin
        mem_addr       = '0;
        mem_write_data = 32'h0;
      end
    endcase
    mem_write_en = rst_n && ((state == WR) || (state == LDW));
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // Main sequencer: accept, access memory, and post a one-cycle response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      addr_q       <= '0;
      funct3_q     <= 3'b000;
      write_q      <= 1'b0;
      wdata_q      <= 32'h0;
      merge_q      <= 32'h0;
      ld_addr_q    <= '0;
      ld_wdata_q   <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_take) begin
            ld_addr_q  <= ld_addr;
            ld_wdata_q <= ld_wdata;
            state      <= LDW;
          end else if (cpu_take) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            write_q  <= req_write;
            wdata_q  <= req_wdata;
            if (req_bad) begin
              resp_valid_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b1;
              state        <= RESP;
            end else if (req_write && (req_funct3 == F3_W)) begin
              state <= WR;
            end else begin
              // loads and sub-word stores both start by reading the word
              state <= RD;
            end
          end
        end
        RD: begin
          if (write_q) begin
            merge_q <= store_word;
            state   <= WR;
          end else begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_data;
            resp_err_q   <= 1'b0;
            state        <= RESP;
          end
        end
        WR: begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
          resp_err_q   <= 1'b0;
          state        <= RESP;
        end
        LDW: begin
          state <= IDLE;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed scoreboard bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .ld_valid       (ld_valid),
    .ld_ready       (ld_ready),
    .ld_addr        (ld_addr),
    .ld_wdata       (ld_wdata),
    .mem_write_en   (mem_write_en),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  logic [31:0] mem [0:15];
  assign mem_read_data = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 32'h0;

  always @(posedge clk)
    if (mem_write_en && (mem_addr < 32'd16)) mem[mem_addr[3:0]] <= mem_write_data;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rdata; logic err; int due; } rexp_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } wexp_t;
  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t re;
  wexp_t we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid) begin
      checks++;
      assert (rq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_resp observed=resp_valid expected=no_response cyc=%0d", cyc);
      end
      if (rq.size() != 0) begin
        re = rq.pop_front();
        chk("resp_rdata", resp_rdata, re.rdata);
        chk("resp_err", {31'h0, resp_err}, {31'h0, re.err});
        chk("resp_cycle", cyc, re.due);
      end
    end
    if (mem_write_en) begin
      checks++;
      assert (wq.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=addr %h data %h expected=no_write", mem_addr, mem_write_data);
      end
      if (wq.size() != 0) begin
        we = wq.pop_front();
        chk("write_addr", mem_addr, we.addr);
        chk("write_data", mem_write_data, we.data);
        chk("write_cycle", cyc, we.due);
      end
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (rq.size() != 0 || wq.size() != 0); i++) @(negedge clk);
    chk({tag, "_resp_pending"}, rq.size(), 0);
    chk({tag, "_write_pending"}, wq.size(), 0);
  endtask

  task automatic ld_write(input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    @(negedge clk);
    ld_addr = a; ld_wdata = d; ld_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (ld_ready) begin
        got = 1'b1;
        wq.push_back('{a, d, cyc + 1});
      end else @(negedge clk);
    end
    chk("ld_accepted", {31'h0, got}, 32'd1);
    @(negedge clk);
    ld_valid = 1'b0;
    drain("ld");
  endtask

  // lat: cycles from acceptance to resp_valid; w_lat: to the write (0 = none)
  task automatic cpu_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int w_lat, input logic [31:0] w_data);
    bit got;
    got = 1'b0;
    @(negedge clk);
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_ready) begin
        got = 1'b1;
        rq.push_back('{exp_rd, exp_err, cyc + lat});
        if (w_lat > 0) wq.push_back('{a >> 2, w_data, cyc + w_lat});
      end else @(negedge clk);
    end
    chk("req_accepted", {31'h0, got}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    drain("req");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  int ld_acc;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; ld_valid = 1'b0; ld_addr = 32'h0; ld_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'h0, resp_err}, 32'd0);
    chk("rst_mem_we", {31'h0, mem_write_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("idle_req_ready", {31'h0, req_ready}, 32'd1);
    chk("idle_ld_ready", {31'h0, ld_ready}, 32'd1);

    ld_write(32'd3, 32'h8899AABB);
    ld_write(32'd4, 32'h12345678);

    // loads: lat 2, no write
    cpu_req(1'b0, 3'b000, 32'h0D, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 0, 32'h0);
    chk("rdata_stable", resp_rdata, 32'hFFFFFFAA);
    cpu_req(1'b0, 3'b100, 32'h0D, 32'h0, 32'h000000AA, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b101, 32'h0E, 32'h0, 32'h00008899, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b001, 32'h0E, 32'h0, 32'hFFFF8899, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b000, 32'h0F, 32'h0, 32'hFFFFFF88, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b000, 32'h0C, 32'h0, 32'hFFFFFFBB, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b001, 32'h0C, 32'h0, 32'hFFFFAABB, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h12345678, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b0, 3'b100, 32'h11, 32'h0, 32'h00000056, 1'b0, 2, 0, 32'h0);

    // sub-word stores: write at +2, resp at +3
    cpu_req(1'b1, 3'b000, 32'h0E, 32'h11, 32'h0, 1'b0, 3, 2, 32'h8811AABB);
    cpu_req(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8811AABB, 1'b0, 2, 0, 32'h0);
    cpu_req(1'b1, 3'b001, 32'h12, 32'hDEADBEEF, 32'h0, 1'b0, 3, 2, 32'hBEEF5678);
    cpu_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hBEEF5678, 1'b0, 2, 0, 32'h0);

    // word store: write at +1, resp at +2
    cpu_req(1'b1, 3'b010, 32'h04, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1, 32'hCAFEF00D);
    cpu_req(1'b0, 3'b101, 32'h06, 32'h0, 32'h0000CAFE, 1'b0, 2, 0, 32'h0);

    // rejected accesses: resp at +1, no write
    cpu_req(1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b0, 3'b001, 32'h0D, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b1, 3'b001, 32'h01, 32'h1234, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b1, 3'b010, 32'h02, 32'h1234, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b1, 3'b100, 32'h00, 32'h55, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b1, 3'b101, 32'h00, 32'h55, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b0, 3'b110, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    cpu_req(1'b0, 3'b111, 32'h00, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
    chk("mem1_after_errors", mem[1], 32'hCAFEF00D);

    // loader and CPU together: loader first, CPU the cycle after LDW
    @(negedge clk);
    ld_addr = 32'd5; ld_wdata = 32'hA5A50001; ld_valid = 1'b1;
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14; req_wdata = 32'h0; req_valid = 1'b1;
    #1;
    chk("prio_ld_ready", {31'h0, ld_ready}, 32'd1);
    chk("prio_req_ready", {31'h0, req_ready}, 32'd0);
    ld_acc = cyc;
    wq.push_back('{32'd5, 32'hA5A50001, ld_acc + 1});
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("prio_req_ready_ldw", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("prio_req_ready_after", {31'h0, req_ready}, 32'd1);
    rq.push_back('{32'hA5A50001, 1'b0, cyc + 2});
    @(negedge clk);
    req_valid = 1'b0;
    drain("prio");

    // reset during the WR cycle of an SH
    @(negedge clk);
    req_write = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0C; req_wdata = 32'h7777; req_valid = 1'b1;
    #1;
    chk("rmw_rst_ready", {31'h0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rmw_rst_we", {31'h0, mem_write_en}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rmw_rst_idle", {31'h0, req_ready}, 32'd1);
    chk("rmw_rst_rdata", resp_rdata, 32'h0);
    repeat (4) @(negedge clk);
    chk("rmw_rst_mem3", mem[3], 32'h8811AABB);
    cpu_req(1'b0, 3'b010, 32'h0C, 32'h0, 32'h8811AABB, 1'b0, 2, 0, 32'h0);

    drain("final");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, CPU access request.
REQ-005 SHALL have port req_ready, output, 1, CPU request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_write, input, 1, 1=store, 0=load.
REQ-007 SHALL have port req_funct3, input, 3, RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have ports req_addr (input, ADDR_W, byte address) and req_wdata (input, 32, store data, LSBs used).
REQ-009 SHALL have ports resp_valid (output, 1, one-cycle completion pulse), resp_rdata (output, 32, load result), resp_err (output, 1, rejected access).
REQ-010 SHALL have ports ld_valid (input, 1), ld_ready (output, 1), ld_addr (input, ADDR_W, word index), ld_wdata (input, 32): program-loader write port.
REQ-011 SHALL have ports mem_write_en (output, 1), mem_addr (output, ADDR_W, word index), mem_write_data (output, 32), mem_read_data (input, 32): word memory with combinational read and write on clock edge.

Function
REQ-012 SHALL implement FSM states IDLE, RD, WR, LDW, RESP.
REQ-013 SHALL assert req_ready and ld_ready only in IDLE; when ld_valid is high, ld_ready=1 and req_ready=0 (fixed loader priority).
REQ-014 SHALL, on loader acceptance, go to LDW: mem_write_en=1, mem_addr=ld_addr, mem_write_data=ld_wdata for one cycle, then IDLE; no resp_valid.
REQ-015 SHALL register req_addr, req_funct3, req_write, and req_wdata on CPU acceptance.
REQ-016 SHALL flag misalignment (H/HU with addr[0]=1; W with addr[1:0]!=0) or an invalid funct3 (011, 110, 111, or BU/HU with req_write=1): IDLE->RESP with resp_err=1, resp_rdata=0, no memory access.
REQ-017 SHALL map byte address to mem_addr = addr >> 2 during RD and WR.
REQ-018 SHALL sequence loads as IDLE->RD->RESP: RD samples mem_read_data; resp_valid is high exactly 2 cycles after acceptance.
REQ-019 SHALL extract loads from the byte lane addr[1:0] (B/BU) or half lane addr[1] (H/HU), sign-extending for B/H and zero-extending for BU/HU; W returns the full word.
REQ-020 SHALL sequence SW as IDLE->WR->RESP, writing req_wdata in WR; resp_valid follows acceptance by 2 cycles.
REQ-021 SHALL sequence SB/SH as read-modify-write, IDLE->RD->WR->RESP: RD captures the word; WR writes it with only the addressed byte or half replaced by req_wdata[7:0] or [15:0]; resp_valid follows acceptance by 3 cycles.
REQ-022 SHALL set resp_rdata=0 for stores, and resp_err=0 for every non-error response.
REQ-023 SHALL hold resp_valid high only in RESP (one cycle), then return to IDLE; no request is accepted in RESP.
REQ-024 SHALL drive mem_write_en=1 only in WR and LDW; in all other states mem_write_en=0 and mem_addr=0.
REQ-025 SHALL keep resp_rdata and resp_err stable from RESP until the next RESP.

Reset
REQ-026 SHALL, at a clock edge with rst_n=0, enter IDLE and clear resp_valid, resp_rdata, resp_err, and all captured request registers to 0.
REQ-027 SHALL gate mem_write_en with rst_n so that no memory write occurs in any cycle in which rst_n=0, including reset asserted mid-RMW.
REQ-028 SHALL, after reset mid-operation, issue no resp_valid for the aborted request.

Structure
REQ-029 SHALL place the funct3 width constants and the FSM state encoding in shared package lsu_pkg.
REQ-030 SHALL place the combinational load extraction/extension and store byte merge in sub-module lsu_align.

Verification
REQ-031 SHALL cover: mem[3]=0x8899AABB, LB at addr 0x0D -> resp_rdata=0xFFFFFFAA at acceptance+2, no write.
REQ-032 SHALL cover: mem[3]=0x8899AABB, SB addr 0x0E wdata 0x11 -> single write mem[3]=0x8811AABB at acceptance+2; resp_valid at +3.
REQ-033 SHALL cover: LW addr 0x06 -> resp_valid with resp_err=1 at +1 after acceptance, mem_write_en never high.
REQ-034 SHALL cover: ld_valid and req_valid both high in IDLE -> loader write first (ld_ready=1, req_ready=0), CPU request accepted the cycle after LDW.
REQ-035 SHALL cover: rst_n low in the WR cycle of an SH -> no write occurs, FSM in IDLE, no resp_valid.
REQ-036 SHALL cover: LHU addr 0x0E with mem[3]=0x8899AABB -> resp_rdata=0x00008899; LH -> 0xFFFF8899.
